lift_motion_controller: RTL

Car motion sequencer that sits directly upstream of the door controller. Latches floor requests and moves the car floor by floor using a SCAN policy (keep direction while work remains ahead). On reaching a requested floor it emits a one-cycle arrival pulse, which drives the door controller's edge input. It then holds the car until the door reports closed.

---
 rtl/lift_motion_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lift_motion_controller.sv
// SCAN-policy car motion sequencer feeding the door controller's arrival edge input.
// Optional door reopen on a current-floor request while waiting: define LIFT_REOPEN_EN.
module lift_motion_controller #(
  parameter int N_FLOORS            = 8,
  parameter int FLOOR_W             = 3,
  parameter int FLOOR_TRAVEL_CYCLES = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [FLOOR_W-1:0]  req_floor,
  input  logic                door_open,
  output logic                arrive_pulse,
  output logic                force_open,
  output logic [FLOOR_W-1:0]  current_floor,
  output logic                moving,
  output logic                dir_up,
  output logic [N_FLOORS-1:0] pending
);

  localparam int CNT_W = $clog2(FLOOR_TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLOOR_TRAVEL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVING, ARRIVE, DOOR_WAIT} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    travel_cnt, travel_cnt_next;
  logic [FLOOR_W-1:0]  floor_next, floor_step;
  logic                dir_next;
  logic [N_FLOORS-1:0] pending_next, req_mask, cur_mask;
  logic                req_ok;
  logic                seen_open, seen_open_next;
`ifdef LIFT_REOPEN_EN
  logic                force_next;
`endif

  // True when any request lies strictly beyond floor f in the given direction.
  function automatic logic work_ahead(input logic [N_FLOORS-1:0] bits,
                                     input logic [FLOOR_W-1:0]  f,
                                     input logic                up);
    logic any;
    any = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (bits[i] && (up ? (i > int'(f)) : (i < int'(f)))) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic bit_at(input logic [N_FLOORS-1:0] bits,
                                  input logic [FLOOR_W-1:0]  f);
    logic [N_FLOORS-1:0] shifted;
    shifted = bits >> f;
    return shifted[0];
  endfunction

  always_comb begin
    req_ok   = req_valid && (int'(req_floor) < N_FLOORS);
    req_mask = req_ok ? (N_FLOORS'(1) << req_floor) : '0;
    cur_mask = N_FLOORS'(1) << current_floor;
    floor_step = dir_up ? (current_floor + FLOOR_W'(1)) : (current_floor - FLOOR_W'(1));
  end

  always_comb begin
    state_next      = state;
    travel_cnt_next = '0;
    floor_next      = current_floor;
    dir_next        = dir_up;
    pending_next    = pending | req_mask;
    seen_open_next  = seen_open;
`ifdef LIFT_REOPEN_EN
    force_next      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bit_at(pending, current_floor)) begin
          state_next = ARRIVE;
        end else if (work_ahead(pending, current_floor, dir_up)) begin
          state_next = MOVING;
        end else if (work_ahead(pending, current_floor, !dir_up)) begin
          dir_next   = !dir_up;
          state_next = MOVING;
        end
      end
      MOVING: begin
        if (travel_cnt == CNT_LAST) begin
          floor_next = floor_step;
          if (bit_at(pending, floor_step)) begin
            state_next = ARRIVE;
          end else if (!work_ahead(pending, floor_step, dir_up)) begin
            state_next = IDLE;
          end
        end else begin
          travel_cnt_next = travel_cnt + CNT_W'(1);
        end
      end
      // The serviced bit is cleared after the merge so a same-cycle request for it is lost.
      ARRIVE: begin
        pending_next   = (pending | req_mask) & ~cur_mask;
        seen_open_next = 1'b0;
        state_next     = DOOR_WAIT;
      end
      DOOR_WAIT: begin
        if (door_open) seen_open_next = 1'b1;
        if (seen_open && !door_open) state_next = IDLE;
`ifdef LIFT_REOPEN_EN
        if (req_ok && (req_floor == current_floor)) begin
          pending_next = pending;
          force_next   = !force_open;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      travel_cnt    <= '0;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
      seen_open     <= 1'b0;
      moving        <= 1'b0;
      arrive_pulse  <= 1'b0;
    end else begin
      state         <= state_next;
      travel_cnt    <= travel_cnt_next;
      current_floor <= floor_next;
      dir_up        <= dir_next;
      pending       <= pending_next;
      seen_open     <= seen_open_next;
      moving        <= (state_next == MOVING);
      arrive_pulse  <= (state_next == ARRIVE);
    end
  end

`ifdef LIFT_REOPEN_EN
  always_ff @(posedge clk) begin
    if (reset) force_open <= 1'b0;
    else       force_open <= force_next;
  end
`else
  assign force_open = 1'b0;
`endif

endmodule
